// File: rtl/hw_stack_if.sv
// Push/pop handshake and status bundle for hw_stack.
// The parameters here must match those of the hw_stack instance it connects to.
interface hw_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clr_err, data_in,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err, data_in,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/hw_stack.sv
// Parametrised LIFO stack with an internal stack pointer and sticky overflow/underflow flags.
// The top of the stack is read combinationally, so a pushed word is visible on the next cycle.
module hw_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input logic         clk,
    input logic         reset_n,
    hw_stack_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty, full;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             ovf_set, unf_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top_idx = AW'(count_q - CW'(1));

    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = AW'(count_q);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty) unf_set = 1'b1;
                else       count_d = count_q - CW'(1);
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    // Pop has nothing to remove, so the push still lands in slot 0.
                    wr_idx  = '0;
                    count_d = CW'(1);
                    unf_set = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
        // A new error in the same cycle as clr_err leaves the flag set.
        ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
        unf_d = unf_set | (unf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= bus.data_in;
    end

    assign bus.data_out  = empty ? '0 : mem[top_idx];
    assign bus.count     = count_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_hw_stack.sv
// Directed bench for hw_stack (WIDTH=16, DEPTH=4): a queue-based reference stack feeds a
// scoreboard of expected status per operation, plus directed spot checks.
module tb_hw_stack;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        int unsigned count;
        logic [15:0] top;
        bit          empty;
        bit          full;
        bit          ovf;
        bit          unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    hw_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    exp_t        sb [$];
    logic [15:0] mstk [$];
    bit          mo = 1'b0;
    bit          mu = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " count"},     32'(bus.count),     32'(e.count));
        chk({tag, " data_out"},  32'(bus.data_out),  32'(e.top));
        chk({tag, " empty"},     32'(bus.empty),     32'(e.empty));
        chk({tag, " full"},      32'(bus.full),      32'(e.full));
        chk({tag, " overflow"},  32'(bus.overflow),  32'(e.ovf));
        chk({tag, " underflow"}, 32'(bus.underflow), 32'(e.unf));
    endtask

    // Called at a negedge: apply one operation across the next rising edge.
    task automatic op(input string tag, input bit p, input bit q, input bit c,
                      input logic [15:0] d);
        exp_t e;
        bit   so = 1'b0;
        bit   su = 1'b0;
        bus.push    = p;
        bus.pop     = q;
        bus.clr_err = c;
        bus.data_in = d;
        if (p && q) begin
            if (mstk.size() == 0) begin
                mstk.push_back(d);
                su = 1'b1;
            end else begin
                mstk[mstk.size() - 1] = d;
            end
        end else if (p) begin
            if (mstk.size() == DEPTH) so = 1'b1;
            else                      mstk.push_back(d);
        end else if (q) begin
            if (mstk.size() == 0) su = 1'b1;
            else                  void'(mstk.pop_back());
        end
        mo = so || (mo && !c);
        mu = su || (mu && !c);
        e.count = mstk.size();
        e.top   = (mstk.size() == 0) ? 16'h0 : mstk[mstk.size() - 1];
        e.empty = (mstk.size() == 0);
        e.full  = (mstk.size() == DEPTH);
        e.ovf   = mo;
        e.unf   = mu;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = 16'h0;
        check_sb(tag);
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = 16'h0;

        #2;
        chk("rst count",     32'(bus.count),     32'd0);
        chk("rst empty",     32'(bus.empty),     32'd1);
        chk("rst full",      32'(bus.full),      32'd0);
        chk("rst overflow",  32'(bus.overflow),  32'd0);
        chk("rst underflow", 32'(bus.underflow), 32'd0);
        chk("rst data_out",  32'(bus.data_out),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic LIFO order
        op("t1 push1", 1, 0, 0, 16'h1111);
        op("t1 push2", 1, 0, 0, 16'h2222);
        op("t1 push3", 1, 0, 0, 16'h3333);
        chk("t1 top3",   32'(bus.data_out), 32'h3333);
        chk("t1 count3", 32'(bus.count),    32'd3);
        op("t1 pop1", 0, 1, 0, 16'h0);
        chk("t1 top2", 32'(bus.data_out), 32'h2222);
        op("t1 pop2", 0, 1, 0, 16'h0);
        chk("t1 top1", 32'(bus.data_out), 32'h1111);
        op("t1 pop3", 0, 1, 0, 16'h0);
        chk("t1 top0",  32'(bus.data_out), 32'h0);
        chk("t1 empty", 32'(bus.empty),    32'd1);

        // Overflow at full, then clear
        for (int i = 1; i <= 4; i++) op("t2 fill", 1, 0, 0, 16'(16'h0A00 + i));
        op("t2 push_full", 1, 0, 0, 16'hDEAD);
        chk("t2 full",     32'(bus.full),     32'd1);
        chk("t2 count",    32'(bus.count),    32'd4);
        chk("t2 overflow", 32'(bus.overflow), 32'd1);
        chk("t2 top",      32'(bus.data_out), 32'h0A04);
        op("t2 clr", 0, 0, 1, 16'h0);
        chk("t2 ovf_clr", 32'(bus.overflow), 32'd0);

        // Underflow, and set beats clear
        for (int i = 0; i < 4; i++) op("t3 drain", 0, 1, 0, 16'h0);
        op("t3 pop_empty", 0, 1, 0, 16'h0);
        chk("t3 underflow", 32'(bus.underflow), 32'd1);
        chk("t3 count",     32'(bus.count),     32'd0);
        op("t3 pop_clr", 0, 1, 1, 16'h0);
        chk("t3 unf_set_wins", 32'(bus.underflow), 32'd1);
        op("t3 clr", 0, 0, 1, 16'h0);
        chk("t3 unf_clr", 32'(bus.underflow), 32'd0);

        // Replace-top with simultaneous push and pop
        op("t4 push1", 1, 0, 0, 16'h1234);
        op("t4 push2", 1, 0, 0, 16'hAAAA);
        op("t4 replace", 1, 1, 0, 16'hBBBB);
        chk("t4 count2", 32'(bus.count),    32'd2);
        chk("t4 top2",   32'(bus.data_out), 32'hBBBB);
        op("t4 push3", 1, 0, 0, 16'h3456);
        op("t4 push4", 1, 0, 0, 16'h4567);
        op("t4 replace_full", 1, 1, 0, 16'hCCCC);
        chk("t4 count4", 32'(bus.count),    32'd4);
        chk("t4 topC",   32'(bus.data_out), 32'hCCCC);
        chk("t4 no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 3; i++) op("t4 drain", 0, 1, 0, 16'h0);
        chk("t4 bottom", 32'(bus.data_out), 32'h1234);
        op("t4 drain_last", 0, 1, 0, 16'h0);

        // Push+pop on empty performs the push and flags underflow
        op("t5 pushpop_empty", 1, 1, 0, 16'h5555);
        chk("t5 count", 32'(bus.count),     32'd1);
        chk("t5 top",   32'(bus.data_out),  32'h5555);
        chk("t5 unf",   32'(bus.underflow), 32'd1);
        op("t5 clr", 0, 0, 1, 16'h0);

        // Asynchronous reset between edges
        op("t6 push2", 1, 0, 0, 16'h6666);
        op("t6 push3", 1, 0, 0, 16'h6767);
        op("t6 push_full", 1, 0, 0, 16'h6868);
        op("t6 ovf", 1, 0, 0, 16'h6969);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6 rst count",     32'(bus.count),     32'd0);
        chk("t6 rst empty",     32'(bus.empty),     32'd1);
        chk("t6 rst data_out",  32'(bus.data_out),  32'd0);
        chk("t6 rst overflow",  32'(bus.overflow),  32'd0);
        chk("t6 rst underflow", 32'(bus.underflow), 32'd0);
        mstk.delete();
        mo = 1'b0;
        mu = 1'b0;
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        op("t6 resume", 1, 0, 0, 16'h7777);
        chk("t6 resume top",   32'(bus.data_out), 32'h7777);
        chk("t6 resume count", 32'(bus.count),    32'd1);
        op("t6 resume2", 1, 0, 0, 16'h7878);
        op("t6 pop", 0, 1, 0, 16'h0);
        chk("t6 mem0", 32'(bus.data_out), 32'h7777);

        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
